load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the 64-bit data-memory interface: turns a pipeline load/store request into mem_read/mem_write/address/write_data cycles and returns the extended load result.
- Handles RV64 access sizes (byte/half/word/double) over a memory port that only moves 8 bytes per access; sub-doubleword stores use read-modify-write.
- Sits between the MEM stage and dataMemory.

Parameters:
- MEM_BYTES, 512, byte size of the attached memory; legal addresses are 0..MEM_BYTES-8.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only when busy=0
- is_store  input  1  1=store, 0=load
- funct3  input  3  RV64 size/sign code
- base  input  64  base register value
- offset  input  64  sign-extended immediate
- store_data  input  64  store source (low bytes used)
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle completion pulse
- error  output  1  valid with done; 1 = request rejected
- load_result  output  64  extended load data, valid with done
- mem_read  output  1  to memory
- mem_write  output  1  to memory
- mem_address  output  64  to memory
- mem_write_data  output  64  to memory
- mem_read_data  input  64  from memory; valid the cycle after mem_read=1

Behaviour:
- Reset: state=IDLE; busy, done, error, mem_read, mem_write = 0; load_result, mem_address, mem_write_data = 0. Reset mid-operation aborts at that edge with no further memory strobes. Memory is unchanged unless the WR edge has already occurred.
- Memory strobes are decoded from state only (Moore): mem_read=1 only in RD; mem_write=1 only in WR.
- mem_address holds the registered addr = base+offset (64-bit, wrap mod 2^64) from accept until the next accept.
- Accept: start=1 in IDLE registers addr, funct3, is_store and store_data. start while busy=1 is ignored.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- Error check at accept: illegal funct3, or addr > MEM_BYTES-8 (unsigned).
  - No memory access is issued; state goes to ERR.
  - Next edge: done=1, error=1, load_result=0, then IDLE.
- States: IDLE, RD, RESP, MERGE, WR, ERR.
- Load: IDLE -> RD -> RESP -> IDLE.
  - At the RESP edge, load_result is taken from mem_read_data low bytes (byte 0 = addr): sign-extended for 000/001/010, zero-extended for 100/101/110, full 64 bits for 011.
  - done=1 in the cycle after RESP, i.e. 3 cycles after the start cycle.
- SD: IDLE -> WR -> IDLE.
  - mem_write_data = store_data.
  - done 2 cycles after start.
- SB/SH/SW: IDLE -> RD -> MERGE -> WR -> IDLE.
  - At the MERGE edge, mem_write_data is registered as mem_read_data with the low 1/2/4 bytes replaced by store_data's low bytes; the upper bytes are preserved.
  - done 4 cycles after start.
- done/error are registered, high exactly one cycle, with state already IDLE. A start in that same cycle is accepted (back-to-back).
- error=0 on every successful completion. load_result is unchanged by stores.

Optional Feature:
- MISALIGN_TRAP_EN defined: at accept, an addr not a multiple of the access size (2/4/8 for H/W/D) takes the ERR path (done+error, no memory access).
- Not defined: misaligned addresses are performed normally, since the memory is byte-addressed; only the range and funct3 checks apply.

Test Plan:
- Reset asserted on a cycle with start=1 -> all outputs 0, no mem strobes, busy=0 next cycle.
- SD: addr 16, data 0x1122334455667788 -> mem_write for exactly 1 cycle, done at +2. Then LD at 16 -> mem_read 1 cycle, done at +3, load_result=0x1122334455667788.
- SB 0xAB to addr 16 over the above -> RD, MERGE, WR sequence, mem_write_data=0x11223344556677AB, done at +4. Then LB at 16 -> 0xFFFFFFFFFFFFFFAB; LBU at 16 -> 0x00000000000000AB.
- LW at 20 after SD 0x80000000_00000000 at 16 -> 0xFFFFFFFF80000000; LWU at 20 -> 0x0000000080000000.
- Load at addr 505 (MEM_BYTES=512), and funct3=111 load -> done+error at +2, no mem_read, load_result=0. Start pulsed while busy -> ignored.
- LH at addr 3 -> with MISALIGN_TRAP_EN: error=1; without: normal result from bytes 3-4.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV64 load/store initiator for an 8-byte-wide, byte-addressed data memory.
// Optional `MISALIGN_TRAP_EN: misaligned half/word/double accesses are rejected as errors.
module load_store_unit #(
  parameter int MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] base,
  input  logic [63:0] offset,
  input  logic [63:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] load_result,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] RESP  = 3'd2;
  localparam logic [2:0] MERGE = 3'd3;
  localparam logic [2:0] WR    = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  logic [2:0]  state;
  logic [63:0] addr_q;
  logic [2:0]  funct3_q;
  logic        is_store_q;
  logic [31:0] store_data_q;

  logic [63:0] req_addr;
  logic        funct3_ok;
  logic        range_ok;
  logic        align_ok;
  logic        req_ok;
  logic [63:0] load_ext;
  logic [63:0] merged;

  assign req_addr = base + offset;

  // Request legality is decided once, at accept, from the live inputs.
  always_comb begin
    funct3_ok = is_store ? (funct3[2] == 1'b0) : (funct3 != 3'b111);
    range_ok  = (req_addr <= MAX_ADDR);
`ifdef MISALIGN_TRAP_EN
    case (funct3[1:0])
      2'b01:   align_ok = (req_addr[0] == 1'b0);
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      2'b11:   align_ok = (req_addr[2:0] == 3'b000);
      default: align_ok = 1'b1;
    endcase
`else
    align_ok = 1'b1;
`endif
    req_ok = funct3_ok && range_ok && align_ok;
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{56{mem_read_data[7]}},  mem_read_data[7:0]};
      3'b001:  load_ext = {{48{mem_read_data[15]}}, mem_read_data[15:0]};
      3'b010:  load_ext = {{32{mem_read_data[31]}}, mem_read_data[31:0]};
      3'b100:  load_ext = {56'd0, mem_read_data[7:0]};
      3'b101:  load_ext = {48'd0, mem_read_data[15:0]};
      3'b110:  load_ext = {32'd0, mem_read_data[31:0]};
      default: load_ext = mem_read_data;
    endcase
  end

  // Sub-doubleword stores overwrite only the low bytes of the doubleword just read.
  always_comb begin
    merged = mem_read_data;
    case (funct3_q[1:0])
      2'b00:   merged[7:0]  = store_data_q[7:0];
      2'b01:   merged[15:0] = store_data_q[15:0];
      2'b10:   merged[31:0] = store_data_q;
      default: merged = mem_read_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      addr_q         <= 64'd0;
      funct3_q       <= 3'd0;
      is_store_q     <= 1'b0;
      store_data_q   <= 32'd0;
      done           <= 1'b0;
      error          <= 1'b0;
      load_result    <= 64'd0;
      mem_write_data <= 64'd0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q       <= req_addr;
            funct3_q     <= funct3;
            is_store_q   <= is_store;
            store_data_q <= store_data[31:0];
            if (!req_ok) begin
              state <= ERR;
            end else if (is_store && (funct3[1:0] == 2'b11)) begin
              mem_write_data <= store_data;
              state          <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD:    state <= is_store_q ? MERGE : RESP;
        RESP: begin
          load_result <= load_ext;
          done        <= 1'b1;
          state       <= IDLE;
        end
        MERGE: begin
          mem_write_data <= merged;
          state          <= WR;
        end
        WR: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        ERR: begin
          done        <= 1'b1;
          error       <= 1'b1;
          load_result <= 64'd0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign mem_read    = (state == RD);
  assign mem_write   = (state == WR);
  assign mem_address = addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array memory model, byte-level reference model,
// directed test-plan cases followed by randomized requests.
module tb_load_store_unit;

  localparam int MEM_BYTES = 512;
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] base = 64'd0;
  logic [63:0] offset = 64'd0;
  logic [63:0] store_data = 64'd0;
  logic        busy, done, error, mem_read, mem_write;
  logic [63:0] load_result, mem_address, mem_write_data;
  logic [63:0] mem_read_data = 64'd0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .store_data(store_data), .busy(busy), .done(done),
    .error(error), .load_result(load_result), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  typedef struct {
    logic        err;
    logic [63:0] result;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          reads;
    int          writes;
    int          lat;
    int          done_cycle;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  mem [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [63:0] last_result = 64'd0;
  int          cycle = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          mem_oob_count = 0;
  int          n_vectors = 0;
  int          n_miscompares = 0;
  bit          abort_phase = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  // Data memory: read data appears the cycle after mem_read, writes land at the WR edge.
  always @(posedge clk) begin
    if (mem_read || mem_write) begin
      if (mem_address > MAX_ADDR) begin
        mem_oob_count++;
      end else begin
        if (mem_read)
          for (int i = 0; i < 8; i++) mem_read_data[8*i +: 8] <= mem[int'(mem_address) + i];
        if (mem_write)
          for (int i = 0; i < 8; i++) mem[int'(mem_address) + i] <= mem_write_data[8*i +: 8];
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    n_vectors++;
    n_miscompares++;
    $display("[TB] FAIL %s: got unexpected event, expected none (t=%0t)", name, $time);
  endtask

  // Reference model: applies the request to a byte array and predicts the response.
  function automatic void model_request(input logic st, input logic [2:0] f3,
                                        input logic [63:0] a, input logic [63:0] sd,
                                        output exp_t e);
    int size;
    bit bad;
    logic [63:0] v;
    size = 1 << f3[1:0];
    bad  = st ? f3[2] : (f3 == 3'b111);
    if (a > MAX_ADDR) bad = 1'b1;
`ifdef MISALIGN_TRAP_EN
    if ((a % size) != 0) bad = 1'b1;
`endif
    e.err = bad; e.addr = a; e.wdata = 64'd0;
    e.reads = 0; e.writes = 0; e.lat = 2; e.done_cycle = 0;
    if (bad) begin
      last_result = 64'd0;
    end else if (st) begin
      for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = sd[8*i +: 8];
      for (int i = 0; i < 8; i++) e.wdata[8*i +: 8] = ref_mem[int'(a) + i];
      e.writes = 1;
      e.reads  = (size == 8) ? 0 : 1;
      e.lat    = (size == 8) ? 2 : 4;
    end else begin
      v = 64'd0;
      for (int i = 0; i < size; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8*i));
      if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8*size));
      last_result = v;
      e.reads = 1;
      e.lat   = 3;
    end
    e.result = last_result;
  endfunction

  // Must be called during the low clock phase; returns just after the accept edge.
  task automatic apply_stimulus(input logic st, input logic [2:0] f3,
                                input logic [63:0] a, input logic [63:0] sd);
    exp_t e;
    logic [63:0] off;
    logic [11:0] imm;
    model_request(st, f3, a, sd, e);
    if ($urandom_range(0, 1) == 1) begin
      imm = 12'($urandom);
      off = {{52{imm[11]}}, imm};
    end else begin
      off = {$urandom, $urandom};
    end
    e.done_cycle = cycle + e.lat;
    sb.push_back(e);
    is_store = st; funct3 = f3; base = a - off; offset = off; store_data = sd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = {$urandom, $urandom}; offset = {$urandom, $urandom}; store_data = {$urandom, $urandom};
  endtask

  // Waits for the scoreboard to drain; returns in the low phase of the done cycle.
  task automatic wait_idle();
    int budget = 12;
    while (budget > 0) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
      budget--;
    end
    if (sb.size() != 0) begin
      report_fail("done_timeout");
      sb.delete();
    end
  endtask

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] sd);
    apply_stimulus(st, f3, a, sd);
    wait_idle();
  endtask

  task automatic do_reset(input logic with_start);
    @(negedge clk);
    reset = 1'b1; start = with_start;
    is_store = 1'b0; funct3 = 3'b011; base = 64'd16; offset = 64'd0;
    @(posedge clk); #1;
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_error", 64'(error), 64'd0);
    check_output("rst_mem_read", 64'(mem_read), 64'd0);
    check_output("rst_mem_write", 64'(mem_write), 64'd0);
    check_output("rst_load_result", load_result, 64'd0);
    check_output("rst_mem_address", mem_address, 64'd0);
    check_output("rst_mem_write_data", mem_write_data, 64'd0);
    sb.delete();
    last_result = 64'd0;
    abort_phase = 1'b0;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_output("post_rst_busy", 64'(busy), 64'd0);
    @(negedge clk); #1;
  endtask

  // Monitor: counts strobes per transaction and checks each completion against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          report_fail("unexpected_done");
        end else begin
          mon_e = sb.pop_front();
          check_output("error", 64'(error), 64'(mon_e.err));
          check_output("load_result", load_result, mon_e.result);
          check_output("done_latency", 64'(cycle), 64'(mon_e.done_cycle));
          check_output("mem_read_cycles", 64'(rd_cnt), 64'(mon_e.reads));
          check_output("mem_write_cycles", 64'(wr_cnt), 64'(mon_e.writes));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
      if (!abort_phase && (mem_read || mem_write)) begin
        if (sb.size() == 0) begin
          report_fail("stray_strobe");
        end else begin
          check_output("mem_address", mem_address, sb[0].addr);
          if (mem_write) check_output("mem_write_data", mem_write_data, sb[0].wdata);
        end
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mism;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] a;

    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    do_reset(1'b1);

    $display("[TB] directed test-plan sequence");
    do_op(1'b1, 3'b011, 64'd16, 64'h1122334455667788);
    do_op(1'b0, 3'b011, 64'd16, 64'd0);
    do_op(1'b1, 3'b000, 64'd16, 64'h00000000000000AB);
    do_op(1'b0, 3'b000, 64'd16, 64'd0);
    do_op(1'b0, 3'b100, 64'd16, 64'd0);
    do_op(1'b1, 3'b011, 64'd16, 64'h8000000000000000);
    do_op(1'b0, 3'b010, 64'd20, 64'd0);
    do_op(1'b0, 3'b110, 64'd20, 64'd0);
    do_op(1'b0, 3'b011, 64'd505, 64'd0);
    do_op(1'b0, 3'b111, 64'd16, 64'd0);
    do_op(1'b1, 3'b100, 64'd16, 64'hDEAD);
    do_op(1'b0, 3'b011, 64'd504, 64'd0);
    do_op(1'b1, 3'b001, 64'd504, 64'h0000BEEF);
    do_op(1'b0, 3'b001, 64'd3, 64'd0);
    do_op(1'b0, 3'b101, 64'd3, 64'd0);
    do_op(1'b1, 3'b010, 64'd6, 64'hCAFEF00D);
    do_op(1'b0, 3'b011, 64'd0, 64'd0);

    // A start held high while busy must not launch a second request.
    apply_stimulus(1'b0, 3'b011, 64'd16, 64'd0);
    start = 1'b1; is_store = 1'b1; funct3 = 3'b011; base = 64'd16; offset = 64'd0;
    store_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk); #1;
    check_output("busy_while_pending", 64'(busy), 64'd1);
    @(negedge clk); #1;
    check_output("busy_while_pending", 64'(busy), 64'd1);
    start = 1'b0;
    wait_idle();

    // Reset while an SB sits in MERGE: no write may reach memory.
    abort_phase = 1'b1;
    is_store = 1'b1; funct3 = 3'b000; base = 64'd16; offset = 64'd0; store_data = 64'h55;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    do_reset(1'b0);
    do_op(1'b0, 3'b011, 64'd16, 64'd0);

    $display("[TB] randomized sequence");
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 19))
        0:       a = {$urandom, $urandom};
        1:       a = 64'($urandom_range(MEM_BYTES - 7, MEM_BYTES + 8));
        default: a = 64'($urandom_range(0, MEM_BYTES - 8));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
      do_op(st, f3, a, {$urandom, $urandom});
    end

    repeat (3) @(negedge clk);
    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) mism++;
    check_output("memory_image_mismatches", 64'(mism), 64'd0);
    check_output("out_of_range_strobes", 64'(mem_oob_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
